ica_iteration_ctrl: RTL and testbench

- Sequences one fixed-point ICA weight-vector iteration loop: vector update engine, then convergence check (difference plus Frobenius norm).
- Compares the returned norm against a programmable IEEE-754 double threshold and repeats until converged, iteration limit reached, error or abort.
- Sits between the top-level ICA scheduler and the update/convergence datapaths. Copies next_vector into vector between iterations via vec_latch.

---
 rtl/ica_iteration_ctrl.sv | 179 +++++++++++++++++
 tb/tb_ica_iteration_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ica_iteration_ctrl.sv
// ICA weight-vector iteration controller: runs update, then convergence check, then
// evaluates the norm and repeats until converged, limit reached, NaN, watchdog or abort.
module ica_iteration_ctrl #(
  parameter int ITER_W  = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ITER_W-1:0] max_iter_i,
  input  logic [63:0]       threshold_i,
  output logic              upd_start_o,
  input  logic              upd_done_i,
  output logic              chk_start_o,
  input  logic              chk_done_i,
  input  logic [63:0]       chk_norm_i,
  output logic              vec_latch_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              converged_o,
  output logic              nan_err_o,
  output logic              timeout_err_o,
  output logic [ITER_W-1:0] iter_count_o
);

  localparam int              WD_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, UPD, CHK, EVAL, LATCH, DONE} state_e;

  state_e            state_q, state_d;
  logic [ITER_W-1:0] max_iter_q, max_iter_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [62:0]       thr_q, thr_d;
  logic [62:0]       norm_q, norm_d;
  logic              conv_q, conv_d;
  logic              nan_q, nan_d;
  logic              tmo_q, tmo_d;
  logic [WD_W-1:0]   wd_q, wd_d;

  logic              wd_expired;
  logic              norm_is_nan;
  logic              norm_below;
  logic              limit_hit;
  logic [ITER_W-1:0] iter_inc;
  logic              unused_sign_bits;

  // Sign bits never matter: magnitudes are compared so -0 behaves like +0.
  assign unused_sign_bits = threshold_i[63] ^ chk_norm_i[63];

  assign wd_expired  = (TIMEOUT != 0) && (wd_q == WD_LIMIT);
  assign norm_is_nan = (&norm_q[62:52]) && (|norm_q[51:0]);
  assign norm_below  = norm_q < thr_q;
  assign iter_inc    = iter_q + ITER_W'(1);
  assign limit_hit   = (max_iter_q != '0) && (iter_inc == max_iter_q);

  assign busy_o        = (state_q != IDLE);
  assign converged_o   = conv_q;
  assign nan_err_o     = nan_q;
  assign timeout_err_o = tmo_q;
  assign iter_count_o  = iter_q;

  always_comb begin
    state_d     = state_q;
    max_iter_d  = max_iter_q;
    iter_d      = iter_q;
    thr_d       = thr_q;
    norm_d      = norm_q;
    conv_d      = conv_q;
    nan_d       = nan_q;
    tmo_d       = tmo_q;
    wd_d        = wd_q;
    upd_start_o = 1'b0;
    chk_start_o = 1'b0;
    vec_latch_o = 1'b0;
    done_o      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          max_iter_d = max_iter_i;
          thr_d      = threshold_i[62:0];
          iter_d     = '0;
          conv_d     = 1'b0;
          nan_d      = 1'b0;
          tmo_d      = 1'b0;
          wd_d       = '0;
          state_d    = UPD;
        end
      end
      UPD: begin
        upd_start_o = !abort_i && !wd_expired;
        if (abort_i) begin
          state_d = DONE;
        end else if (upd_done_i) begin
          wd_d    = '0;
          state_d = CHK;
        end else if (wd_expired) begin
          tmo_d   = 1'b1;
          state_d = DONE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      CHK: begin
        chk_start_o = !abort_i && !wd_expired;
        if (abort_i) begin
          state_d = DONE;
        end else if (chk_done_i) begin
          norm_d  = chk_norm_i[62:0];
          state_d = EVAL;
        end else if (wd_expired) begin
          tmo_d   = 1'b1;
          state_d = DONE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      EVAL: begin
        if (abort_i) begin
          state_d = DONE;
        end else begin
          iter_d = (&iter_q) ? iter_q : iter_inc;
          if (norm_is_nan) begin
            nan_d   = 1'b1;
            state_d = DONE;
          end else if (norm_below) begin
            conv_d  = 1'b1;
            state_d = DONE;
          end else if (limit_hit) begin
            state_d = DONE;
          end else begin
            state_d = LATCH;
          end
        end
      end
      LATCH: begin
        vec_latch_o = !abort_i;
        if (abort_i) begin
          state_d = DONE;
        end else begin
          wd_d    = '0;
          state_d = UPD;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      max_iter_q <= '0;
      iter_q     <= '0;
      thr_q      <= '0;
      norm_q     <= '0;
      conv_q     <= 1'b0;
      nan_q      <= 1'b0;
      tmo_q      <= 1'b0;
      wd_q       <= '0;
    end else begin
      state_q    <= state_d;
      max_iter_q <= max_iter_d;
      iter_q     <= iter_d;
      thr_q      <= thr_d;
      norm_q     <= norm_d;
      conv_q     <= conv_d;
      nan_q      <= nan_d;
      tmo_q      <= tmo_d;
      wd_q       <= wd_d;
    end
  end

endmodule

// File: tb/tb_ica_iteration_ctrl.sv
// Scoreboard bench for ica_iteration_ctrl: directed runs push expected completion
// records; a negedge monitor pops one per done pulse and compares status.
module tb_ica_iteration_ctrl;
  localparam int          ITER_W  = 16;
  localparam int          TIMEOUT = 16;
  localparam logic [63:0] HALF    = 64'h3FE0000000000000;
  localparam logic [63:0] TH_1E6  = 64'h3EB0C6F7A0B5ED8D;
  localparam logic [63:0] N_1E7   = 64'h3E7AD7F29ABCAF48;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_i, abort_i;
  logic [ITER_W-1:0] max_iter_i;
  logic [63:0]       threshold_i;
  logic              upd_start_o, upd_done_i;
  logic              chk_start_o, chk_done_i;
  logic [63:0]       chk_norm_i;
  logic              vec_latch_o, busy_o, done_o;
  logic              converged_o, nan_err_o, timeout_err_o;
  logic [ITER_W-1:0] iter_count_o;

  typedef struct {
    logic              conv;
    logic              nan;
    logic              tmo;
    logic [ITER_W-1:0] iter;
    int                latches;
    bit                checkLat;
  } result_t;

  result_t     expQ[$];
  logic [63:0] normQ[$];
  int checks = 0, failures = 0;
  int latchCount = 0, doneCount = 0;
  int cyc = 0, lastChkCyc = 0;
  int updCnt = 0, chkCnt = 0, chkBudget = 1000;
  bit updEnable = 1'b1;
  int entry;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ica_iteration_ctrl #(.ITER_W(ITER_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .max_iter_i(max_iter_i), .threshold_i(threshold_i),
    .upd_start_o(upd_start_o), .upd_done_i(upd_done_i),
    .chk_start_o(chk_start_o), .chk_done_i(chk_done_i), .chk_norm_i(chk_norm_i),
    .vec_latch_o(vec_latch_o), .busy_o(busy_o), .done_o(done_o),
    .converged_o(converged_o), .nan_err_o(nan_err_o),
    .timeout_err_o(timeout_err_o), .iter_count_o(iter_count_o)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic pushExp(input logic conv, input logic nan, input logic tmo,
                         input logic [ITER_W-1:0] iter, input int latches, input bit checkLat);
    result_t r;
    r.conv = conv; r.nan = nan; r.tmo = tmo;
    r.iter = iter; r.latches = latches; r.checkLat = checkLat;
    expQ.push_back(r);
  endtask

  // Inputs change after sampling so an uncaptured limit/threshold would be exposed.
  task automatic applyStimulus(input logic [ITER_W-1:0] maxIter, input logic [63:0] thr);
    @(posedge clk); #1;
    latchCount  = 0;
    max_iter_i  = maxIter;
    threshold_i = thr;
    start_i     = 1'b1;
    @(posedge clk); #1;
    start_i     = 1'b0;
    max_iter_i  = '1;
    threshold_i = '0;
    checkOutput("start_busy", busy_o, 1);
    checkOutput("start_upd_latency", upd_start_o, 1);
    checkOutput("start_clr_iter", iter_count_o, 0);
    checkOutput("start_clr_conv", converged_o, 0);
    checkOutput("start_clr_nan", nan_err_o, 0);
    checkOutput("start_clr_tmo", timeout_err_o, 0);
  endtask

  task automatic waitDone(input string name);
    int startCount = doneCount;
    for (int i = 0; i < 500 && doneCount == startCount; i++) @(posedge clk);
    if (doneCount == startCount) begin
      checks++; failures++;
      $display("[TB] FAIL %s_done_wait actual=none required=done", name);
    end
    @(posedge clk); #1;
  endtask

  task automatic waitLatch(input int n);
    for (int i = 0; i < 200 && latchCount < n; i++) @(negedge clk);
    if (latchCount < n) begin
      checks++; failures++;
      $display("[TB] FAIL latch_wait actual=%0d required=%0d", latchCount, n);
    end
  endtask

  task automatic waitChkStart();
    for (int i = 0; i < 200 && !chk_start_o; i++) @(negedge clk);
    if (!chk_start_o) begin
      checks++; failures++;
      $display("[TB] FAIL chk_start_wait actual=0 required=1");
    end
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_busy"}, busy_o, 0);
    checkOutput({name, "_done"}, done_o, 0);
    checkOutput({name, "_upd_start"}, upd_start_o, 0);
    checkOutput({name, "_chk_start"}, chk_start_o, 0);
    checkOutput({name, "_vec_latch"}, vec_latch_o, 0);
    checkOutput({name, "_converged"}, converged_o, 0);
    checkOutput({name, "_nan_err"}, nan_err_o, 0);
    checkOutput({name, "_timeout_err"}, timeout_err_o, 0);
    checkOutput({name, "_iter_count"}, iter_count_o, 0);
  endtask

  // Update engine answers after 3 request cycles, convergence check after 2.
  initial begin
    upd_done_i = 1'b0; chk_done_i = 1'b0; chk_norm_i = '0;
    forever begin
      @(posedge clk); #1;
      upd_done_i = 1'b0;
      chk_done_i = 1'b0;
      if (upd_start_o && updEnable) begin
        updCnt++;
        if (updCnt == 3) begin upd_done_i = 1'b1; updCnt = 0; end
      end else updCnt = 0;
      if (chk_start_o && chkBudget > 0) begin
        chkCnt++;
        if (chkCnt == 2) begin
          chk_done_i = 1'b1;
          chkCnt     = 0;
          chkBudget--;
          lastChkCyc = cyc;
          if (normQ.size() > 0) chk_norm_i = normQ.pop_front();
          else chk_norm_i = HALF;
        end
      end else chkCnt = 0;
    end
  end

  always @(negedge clk) begin
    result_t r;
    if (!rst) begin
      if (vec_latch_o) latchCount++;
      if (done_o) begin
        doneCount++;
        if (expQ.size() == 0) begin
          checks++; failures++;
          $display("[TB] FAIL unexpected_done actual=1 expected=0");
        end else begin
          r = expQ.pop_front();
          checkOutput("converged", converged_o, r.conv);
          checkOutput("nan_err", nan_err_o, r.nan);
          checkOutput("timeout_err", timeout_err_o, r.tmo);
          checkOutput("iter_count", iter_count_o, r.iter);
          checkOutput("vec_latch_pulses", latchCount, r.latches);
          if (r.checkLat) checkOutput("chk_done_to_done", cyc - lastChkCyc, 2);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL global_time_limit actual=expired required=finish");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; max_iter_i = '0; threshold_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Converges on the third iteration.
    normQ.push_back(HALF); normQ.push_back(HALF); normQ.push_back(N_1E7);
    pushExp(1'b1, 1'b0, 1'b0, 16'd3, 2, 1'b1);
    applyStimulus(16'd10, TH_1E6);
    waitDone("converge3");

    // Iteration limit of 4 with a norm that never converges.
    repeat (4) normQ.push_back(HALF);
    pushExp(1'b0, 1'b0, 1'b0, 16'd4, 3, 1'b0);
    applyStimulus(16'd4, TH_1E6);
    waitDone("limit4");

    normQ.push_back(64'h7FF8000000000000);
    pushExp(1'b0, 1'b1, 1'b0, 16'd1, 0, 1'b0);
    applyStimulus(16'd10, TH_1E6);
    waitDone("nan");

    // Negative zero compares as a magnitude below 1.0.
    normQ.push_back(64'h8000000000000000);
    pushExp(1'b1, 1'b0, 1'b0, 16'd1, 0, 1'b1);
    applyStimulus(16'd5, 64'h3FF0000000000000);
    waitDone("neg_zero");

    // +Inf never converges, even against the largest finite threshold.
    normQ.push_back(64'h7FF0000000000000);
    pushExp(1'b0, 1'b0, 1'b0, 16'd1, 0, 1'b0);
    applyStimulus(16'd1, 64'h7FEFFFFFFFFFFFFF);
    waitDone("pos_inf");

    updEnable = 1'b0;
    pushExp(1'b0, 1'b0, 1'b1, 16'd0, 0, 1'b0);
    applyStimulus(16'd10, TH_1E6);
    entry = cyc;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cyc - entry == 15) checkOutput("wdog_upd_held", upd_start_o, 1);
      if (cyc - entry == 16) checkOutput("wdog_upd_drop", upd_start_o, 0);
      if (done_o) break;
    end
    checkOutput("wdog_done_latency", cyc - entry, 17);
    updEnable = 1'b1;
    @(posedge clk); #1;

    // Abort during the second check; a start pulse while busy must be ignored.
    chkBudget = 1;
    normQ.push_back(HALF);
    pushExp(1'b0, 1'b0, 1'b0, 16'd1, 1, 1'b0);
    applyStimulus(16'd10, TH_1E6);
    waitLatch(1);
    @(posedge clk); #1;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    checkOutput("busy_start_ignored_iter", iter_count_o, 1);
    checkOutput("busy_start_ignored_busy", busy_o, 1);
    waitChkStart();
    @(posedge clk); #1;
    abort_i = 1'b1;
    @(negedge clk);
    checkOutput("abort_drops_chk_start", chk_start_o, 0);
    @(posedge clk); #1;
    abort_i = 1'b0;
    @(negedge clk);
    checkOutput("abort_done_next_cycle", done_o, 1);
    @(posedge clk); #1;

    // Asynchronous reset while waiting in the second check.
    chkBudget = 1;
    normQ.push_back(HALF);
    applyStimulus(16'd10, TH_1E6);
    waitLatch(1);
    waitChkStart();
    #2;
    rst = 1'b1;
    #1;
    checkAllZero("async_rst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chkBudget = 1000;
    normQ.delete();

    normQ.push_back(N_1E7);
    pushExp(1'b1, 1'b0, 1'b0, 16'd1, 0, 1'b1);
    applyStimulus(16'd0, TH_1E6);
    waitDone("after_reset");

    checkOutput("scoreboard_drained", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
